// File: rtl/pzcorebus_response_generator.sv
// pzcorebus_response_generator: queues non-posted command descriptors and drives the response channel.
// Define PZCOREBUS_RESPONSE_GENERATOR_ERROR_EN to forward i_data_error onto o_serror for read beats.
module pzcorebus_response_generator #(
   parameter int ID_WIDTH     = 8,
   parameter int DATA_WIDTH   = 64,
   parameter int LENGTH_WIDTH = 8,
   parameter int DEPTH        = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   input  logic                    i_cmd_read,
   input  logic [ID_WIDTH-1:0]     i_cmd_id,
   input  logic [LENGTH_WIDTH-1:0] i_cmd_length,
   input  logic                    i_data_valid,
   output logic                    o_data_ready,
   input  logic [DATA_WIDTH-1:0]   i_data,
   input  logic                    i_data_error,
   output logic                    o_sresp_valid,
   input  logic                    i_mresp_accept,
   output logic                    o_sresp,
   output logic [ID_WIDTH-1:0]     o_sid,
   output logic                    o_serror,
   output logic [DATA_WIDTH-1:0]   o_sdata,
   output logic                    o_sresp_last
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 1 + ID_WIDTH + LENGTH_WIDTH;
   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] WRITE_RESP = 2'd1;
   localparam logic [1:0] READ_DATA  = 2'd2;
`ifdef PZCOREBUS_RESPONSE_GENERATOR_ERROR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif
   logic [EW-1:0]           r_fifo [DEPTH];
   logic [AW:0]             r_wp, r_rp;
   logic [1:0]              r_state;
   logic [ID_WIDTH-1:0]     r_id;
   logic [LENGTH_WIDTH-1:0] r_len;
   logic [LENGTH_WIDTH:0]   r_cnt;
   logic                    r_valid, r_sresp, r_serror, r_last;
   logic [ID_WIDTH-1:0]     r_sid;
   logic [DATA_WIDTH-1:0]   r_sdata;
   logic                    w_full, w_empty, w_push, w_pop, w_free, w_beat, w_last;
   logic                    w_head_read;
   logic [ID_WIDTH-1:0]     w_head_id;
   logic [LENGTH_WIDTH-1:0] w_head_len;
   assign {w_head_read, w_head_id, w_head_len} = r_fifo[r_rp[AW-1:0]];
   assign w_empty = r_wp == r_rp;
   assign w_full = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign o_cmd_ready = !w_full && !i_rst;
   assign w_push = i_cmd_valid && o_cmd_ready;
   assign w_free = !r_valid || i_mresp_accept;
   assign w_pop = (r_state == IDLE) && !w_empty && w_free;
   assign o_data_ready = (r_state == READ_DATA) && w_free;
   assign w_beat = i_data_valid && o_data_ready;
   // a zero length field stands for 2^LENGTH_WIDTH beats
   assign w_last = (r_cnt + 1'b1) == {r_len == '0, r_len};
   assign o_sresp_valid = r_valid;
   assign o_sresp = r_sresp;
   assign o_sid = r_sid;
   assign o_serror = r_serror;
   assign o_sdata = r_sdata;
   assign o_sresp_last = r_last;
   always_ff @(posedge i_clk) begin
      if (w_push) r_fifo[r_wp[AW-1:0]] <= {i_cmd_read, i_cmd_id, i_cmd_length};
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wp <= '0;
         r_rp <= '0;
         r_state <= IDLE;
         r_id <= '0;
         r_len <= '0;
         r_cnt <= '0;
         r_valid <= 1'b0;
         r_sresp <= 1'b0;
         r_sid <= '0;
         r_serror <= 1'b0;
         r_sdata <= '0;
         r_last <= 1'b0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_free) r_valid <= 1'b0;
         // write beat is loaded together with the pop so it shows two cycles after acceptance
         if (w_pop) begin
            r_rp <= r_rp + 1'b1;
            r_id <= w_head_id;
            r_len <= w_head_len;
            r_cnt <= '0;
            r_state <= w_head_read ? READ_DATA : WRITE_RESP;
            if (!w_head_read) begin
               r_valid <= 1'b1;
               r_sresp <= 1'b0;
               r_sid <= w_head_id;
               r_serror <= 1'b0;
               r_sdata <= '0;
               r_last <= 1'b1;
            end
         end else if (r_state == WRITE_RESP) begin
            r_state <= IDLE;
         end else if (w_beat) begin
            r_valid <= 1'b1;
            r_sresp <= 1'b1;
            r_sid <= r_id;
            r_serror <= ERR_EN & i_data_error;
            r_sdata <= i_data;
            r_last <= w_last;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_pzcorebus_response_generator.sv
// tb_pzcorebus_response_generator: scoreboard bench for the response generator (LENGTH_WIDTH=2, DEPTH=4).
module tb_pzcorebus_response_generator;
`ifdef PZCOREBUS_RESPONSE_GENERATOR_ERROR_EN
   localparam logic EN = 1'b1;
`else
   localparam logic EN = 1'b0;
`endif
   logic clk, rst;
   logic cmd_valid, cmd_ready, cmd_read;
   logic [7:0] cmd_id;
   logic [1:0] cmd_length;
   logic data_valid, data_ready, data_error;
   logic [63:0] data;
   logic sresp_valid, mresp_accept, sresp, serror, sresp_last;
   logic [7:0] sid;
   logic [63:0] sdata;
   logic [74:0] q[$];
   logic [64:0] dq[$];
   logic acc_q[$];
   logic acc_default = 1'b1;
   logic dtake = 1'b0;
   logic consec_en = 1'b0;
   int total = 0, bad = 0, cyc = 0, acc_cyc = 0, last_hs = 0;
   logic prev_last = 1'b1;

   pzcorebus_response_generator #(.ID_WIDTH(8), .DATA_WIDTH(64), .LENGTH_WIDTH(2), .DEPTH(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_read(cmd_read),
      .i_cmd_id(cmd_id), .i_cmd_length(cmd_length),
      .i_data_valid(data_valid), .o_data_ready(data_ready), .i_data(data), .i_data_error(data_error),
      .o_sresp_valid(sresp_valid), .i_mresp_accept(mresp_accept), .o_sresp(sresp), .o_sid(sid),
      .o_serror(serror), .o_sdata(sdata), .o_sresp_last(sresp_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: scoreboard pops on each handshake, plus hold checks while stalled
   initial begin
      logic [74:0] e, held;
      logic stalled;
      stalled = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (stalled) begin
            chk("hold_valid", sresp_valid, 1'b1);
            chk("hold_fields", {sresp, sid, serror, sdata, sresp_last}, held);
         end
         if (sresp_valid && !mresp_accept) begin
            chk("stall_data_ready", data_ready, 1'b0);
            held = {sresp, sid, serror, sdata, sresp_last};
            stalled = 1'b1;
         end else stalled = 1'b0;
         if (sresp_valid && mresp_accept) begin
            if (q.size() == 0) chk("unexpected_resp", {sresp, sid, serror, sdata, sresp_last}, 128'hx);
            else begin
               e = q.pop_front();
               chk("resp", {sresp, sid, serror, sdata, sresp_last}, e);
               if (consec_en && !prev_last) chk("consecutive", cyc - last_hs, 1);
               prev_last = e[0];
            end
            last_hs = cyc;
         end
         dtake = data_valid && data_ready;
      end
   end

   initial begin
      data_valid = 1'b0;
      data = '0;
      data_error = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (dtake && dq.size() != 0) void'(dq.pop_front());
         data_valid = dq.size() != 0;
         {data_error, data} = data_valid ? dq[0] : 65'd0;
      end
   end

   initial begin
      mresp_accept = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (sresp_valid && acc_q.size() != 0) mresp_accept = acc_q.pop_front();
         else mresp_accept = acc_default;
      end
   end

   task automatic cmd(input logic rd, input logic [7:0] id, input logic [1:0] len,
                      input logic [63:0] base, input logic [3:0] emask);
      int n;
      logic ok;
      n = (len == 2'd0) ? 4 : int'(len);
      if (!rd) q.push_back({1'b0, id, 1'b0, 64'd0, 1'b1});
      else for (int k = 0; k < n; k++) begin
         dq.push_back({emask[k], base + 64'(k)});
         q.push_back({1'b1, id, emask[k] & EN, base + 64'(k), k == n - 1});
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_read = rd;
      cmd_id = id;
      cmd_length = len;
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            acc_cyc = cyc;
            break;
         end
      end
      if (!ok) chk("cmd_timeout", 0, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      logic ok;
      ok = 1'b0;
      for (int t = 0; t < 500; t++) begin
         @(negedge clk);
         if (q.size() == 0 && !sresp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("drain_timeout", q.size(), 0);
   endtask

   initial begin
      logic found;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_read = 1'b0;
      cmd_id = '0;
      cmd_length = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_outputs", {sresp_valid, data_ready, sresp, sid, serror, sdata, sresp_last}, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", cmd_ready, 1'b1);
      chk("post_rst_valid", sresp_valid, 1'b0);

      cmd(1'b0, 8'h12, 2'd0, 64'd0, 4'd0);
      found = 1'b0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (sresp_valid) begin
            chk("wr_latency", cyc - acc_cyc, 2);
            found = 1'b1;
            break;
         end
      end
      if (!found) chk("wr_latency_timeout", 0, 1);
      drain();

      consec_en = 1'b1;
      cmd(1'b1, 8'h05, 2'd0, 64'hA0, 4'd0);
      drain();
      consec_en = 1'b0;
      cmd(1'b1, 8'h06, 2'd3, 64'hB0, 4'd0);
      cmd(1'b1, 8'h08, 2'd1, 64'hC0, 4'd0);
      cmd(1'b0, 8'h09, 2'd2, 64'd0, 4'd0);
      drain();

      acc_default = 1'b0;
      cmd(1'b0, 8'h20, 2'd0, 64'd0, 4'd0);
      cmd(1'b0, 8'h21, 2'd0, 64'd0, 4'd0);
      cmd(1'b1, 8'h22, 2'd2, 64'hD0, 4'd0);
      cmd(1'b0, 8'h23, 2'd0, 64'd0, 4'd0);
      @(negedge clk);
      chk("ready_before_full", cmd_ready, 1'b1);
      cmd(1'b0, 8'h24, 2'd0, 64'd0, 4'd0);
      @(negedge clk);
      chk("ready_when_full", cmd_ready, 1'b0);
      fork
         cmd(1'b0, 8'h25, 2'd0, 64'd0, 4'd0);
         begin
            repeat (5) @(posedge clk);
            #2;
            acc_default = 1'b1;
         end
      join
      drain();

      acc_q.push_back(1'b1);
      acc_q.push_back(1'b0);
      acc_q.push_back(1'b0);
      acc_q.push_back(1'b1);
      cmd(1'b1, 8'h07, 2'd3, 64'hE0, 4'b0010);
      drain();

      chk("scoreboard_empty", q.size(), 0);
      chk("data_queue_empty", dq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
